// File: rtl/msg_padder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msg_padder_pkg
// Description : Shared constants and FSM state encoding for the message padder.
// Revision    : 1.0 - initial release
// ============================================================================
package msg_padder_pkg;

    localparam int          BLK_WORDS  = 16;
    localparam int          ROUNDS     = 64;
    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    localparam logic [1:0]  ST_COLLECT = 2'd0;
    localparam logic [1:0]  ST_FILL    = 2'd1;
    localparam logic [1:0]  ST_EMIT    = 2'd2;

endpackage : msg_padder_pkg
`default_nettype wire

// File: rtl/msg_padder_if.sv
`default_nettype none
// ============================================================================
// Module      : msg_padder_if
// Description : Word input handshake and round-output bus of the padder.
// Revision    : 1.0 - initial release
// ============================================================================
interface msg_padder_if;

    logic [31:0] in_data;
    logic [2:0]  in_nbytes;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_word;
    logic        sel;
    logic        out_valid;
    logic [5:0]  round;
    logic        blk_first;
    logic        msg_done;

    modport master (
        output in_data, in_nbytes, in_last, in_valid,
        input  in_ready, out_word, sel, out_valid, round, blk_first, msg_done
    );

    modport slave (
        input  in_data, in_nbytes, in_last, in_valid,
        output in_ready, out_word, sel, out_valid, round, blk_first, msg_done
    );

endinterface : msg_padder_if
`default_nettype wire

// File: rtl/msg_padder_pad_word.sv
`default_nettype none
// ============================================================================
// Module      : pad_word
// Description : Keeps the valid leading bytes of a final word, appends 0x80.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_word (
    input  wire logic [31:0] i_data,
    input  wire logic [2:0]  i_nbytes,
    output logic      [31:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < i_nbytes) begin
                o_word[31-8*b -: 8] = i_data[31-8*b -: 8];
            end else if (3'(b) == i_nbytes) begin
                o_word[31-8*b -: 8] = 8'h80;
            end
        end
    end

endmodule : pad_word
`default_nettype wire

// File: rtl/msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : msg_padder
// Description : Collects message words into 16-word blocks, pads them and
//               streams each block as 64 rounds to the expansion stage.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_padder
    import msg_padder_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst_n,
    msg_padder_if.slave  bus
);

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [5:0]  r_round;
    logic [63:0] r_len;
    logic        r_marker_done;
    logic        r_first_blk;
    logic        r_len_ok;   // length words may go into the current block
    logic        r_pending;  // last word seen, padding still owed
    logic        r_final;    // current block carries the length
    logic [31:0] r_buf [BLK_WORDS];

    logic [31:0] w_pad;
    logic [63:0] w_len_next;
    logic [31:0] w_fill_word;
    logic        w_len_lo;
    logic        w_emit;

    pad_word u_pad_word (
        .i_data   (bus.in_data),
        .i_nbytes (bus.in_nbytes),
        .o_word   (w_pad)
    );

    assign w_len_next = r_len + {58'd0, bus.in_nbytes, 3'b000};
    assign w_len_lo   = r_marker_done && r_len_ok && (r_idx == 4'd15);

    always_comb begin
        w_fill_word = '0;
        if (!r_marker_done) begin
            w_fill_word = PAD_MARKER;
        end else if (r_len_ok && r_idx == 4'd14) begin
            w_fill_word = r_len[63:32];
        end else if (w_len_lo) begin
            w_fill_word = r_len[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_COLLECT;
            r_idx         <= '0;
            r_round       <= '0;
            r_len         <= '0;
            r_marker_done <= 1'b0;
            r_first_blk   <= 1'b1;
            r_len_ok      <= 1'b0;
            r_pending     <= 1'b0;
            r_final       <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (bus.in_valid) begin
                        r_len <= w_len_next;
                        r_idx <= r_idx + 4'd1;
                        if (!bus.in_last) begin
                            r_buf[r_idx] <= bus.in_data;
                            if (r_idx == 4'd15) r_state <= ST_EMIT;
                        end else begin
                            r_pending <= 1'b1;
                            // A full block must be emitted before any fill can start
                            r_state   <= (r_idx == 4'd15) ? ST_EMIT : ST_FILL;
                            if (bus.in_nbytes < 3'd4) begin
                                r_buf[r_idx]  <= w_pad;
                                r_marker_done <= 1'b1;
                                r_len_ok      <= (r_idx <= 4'd13);
                            end else begin
                                r_buf[r_idx]  <= bus.in_data;
                                r_marker_done <= 1'b0;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    r_buf[r_idx] <= w_fill_word;
                    r_idx        <= r_idx + 4'd1;
                    if (!r_marker_done) begin
                        r_marker_done <= 1'b1;
                        r_len_ok      <= (r_idx <= 4'd13);
                    end
                    if (w_len_lo) r_final <= 1'b1;
                    if (r_idx == 4'd15) r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    r_round <= r_round + 6'd1;
                    if (r_round == 6'(ROUNDS - 1)) begin
                        r_round <= '0;
                        r_idx   <= '0;
                        if (r_final) begin
                            r_len         <= '0;
                            r_marker_done <= 1'b0;
                            r_first_blk   <= 1'b1;
                            r_len_ok      <= 1'b0;
                            r_pending     <= 1'b0;
                            r_final       <= 1'b0;
                            r_state       <= ST_COLLECT;
                        end else begin
                            r_first_blk <= 1'b0;
                            if (r_marker_done) r_len_ok <= 1'b1;
                            r_state <= r_pending ? ST_FILL : ST_COLLECT;
                        end
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    // Outputs are decoded from registered state and held quiet while in reset
    assign w_emit        = rst_n && (r_state == ST_EMIT);
    assign bus.in_ready  = rst_n && (r_state == ST_COLLECT);
    assign bus.out_valid = w_emit;
    assign bus.round     = w_emit ? r_round : 6'd0;
    assign bus.sel       = w_emit && (r_round >= 6'(BLK_WORDS));
    assign bus.out_word  = (w_emit && r_round < 6'(BLK_WORDS)) ? r_buf[r_round[3:0]] : 32'd0;
    assign bus.blk_first = w_emit && r_first_blk && (r_round == 6'd0);
    assign bus.msg_done  = w_emit && r_final && (r_round == 6'(ROUNDS - 1));

endmodule : msg_padder
`default_nettype wire

// File: tb/tb_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_msg_padder
// Description : Directed scoreboard bench for msg_padder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_padder;

    typedef struct packed {
        logic [31:0] word;
        logic        sel;
        logic [5:0]  rnd;
        logic        first;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    exp_t        exp_q[$];
    exp_t        mon_e;
    exp_t        mon_a;
    logic [31:0] blk [16];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    msg_padder_if bus ();

    msg_padder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    endtask

    task automatic push_block(input bit first, input bit done);
        for (int k = 0; k < 64; k++) begin
            exp_t e;
            e.word  = (k < 16) ? blk[k] : 32'h0;
            e.sel   = (k >= 16);
            e.rnd   = 6'(k);
            e.first = first && (k == 0);
            e.done  = done && (k == 63);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] nb, input bit last, input bit gaps);
        int n;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.in_data   = d;
        bus.in_nbytes = nb;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_20(input bit gaps);
        clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = 32'hC000_0000 + 32'(i);
        push_block(1'b1, 1'b0);
        clear_blk();
        for (int i = 0; i < 4; i++) blk[i] = 32'hC000_0010 + 32'(i);
        blk[4]  = 32'h8000_0000;
        blk[15] = 32'h0000_0280;
        push_block(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) send(32'hC000_0000 + 32'(i), 3'd4, i == 19, gaps);
        wait_drain(gaps ? "drain_20_gaps" : "drain_20");
    endtask

    task automatic run_abc();
        clear_blk();
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
        push_block(1'b1, 1'b1);
        send(32'h6162_6300, 3'd3, 1'b1, 1'b0);
        wait_drain("drain_abc");
    endtask

    // Scoreboard monitor: every output cycle is matched against the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.out_valid === 1'b1) begin
                mon_a = {bus.out_word, bus.sel, bus.round, bus.blk_first, bus.msg_done};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got round=%0d word=%h, expected no output", bus.round, bus.out_word);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_a !== mon_e) begin
                        errors++;
                        $display("FAIL round_out: got word=%h sel=%b round=%0d first=%b done=%b, expected word=%h sel=%b round=%0d first=%b done=%b",
                                 mon_a.word, mon_a.sel, mon_a.rnd, mon_a.first, mon_a.done,
                                 mon_e.word, mon_e.sel, mon_e.rnd, mon_e.first, mon_e.done);
                    end
                end
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_emit: got %b, expected 0", bus.in_ready);
                end
            end else if ({bus.out_valid, bus.out_word, bus.sel, bus.round, bus.blk_first, bus.msg_done} !== '0) begin
                errors++;
                $display("FAIL idle_outputs: got valid=%b word=%h sel=%b round=%0d first=%b done=%b, expected all 0",
                         bus.out_valid, bus.out_word, bus.sel, bus.round, bus.blk_first, bus.msg_done);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_nbytes = 3'd0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_word",  {32'd0, bus.out_word},  64'd0);
        chk("rst_sel_round", {57'd0, bus.sel, bus.round}, 64'd0);
        chk("rst_pulses",    {62'd0, bus.blk_first, bus.msg_done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        run_abc();

        // Empty message; payload bits must be ignored
        clear_blk();
        blk[0] = 32'h8000_0000;
        push_block(1'b1, 1'b1);
        send(32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0);
        wait_drain("drain_empty");

        // One valid byte in the last word
        clear_blk();
        blk[0]  = 32'h4180_0000;
        blk[15] = 32'h0000_0008;
        push_block(1'b1, 1'b1);
        send(32'h41FF_FFFF, 3'd1, 1'b1, 1'b0);
        wait_drain("drain_1byte");

        // Full word then two-byte tail
        clear_blk();
        blk[0]  = 32'h1122_3344;
        blk[1]  = 32'h5566_8000;
        blk[15] = 32'h0000_0030;
        push_block(1'b1, 1'b1);
        send(32'h1122_3344, 3'd4, 1'b0, 1'b0);
        send(32'h5566_FFFF, 3'd2, 1'b1, 1'b0);
        wait_drain("drain_2word");

        // 14 full words: marker lands at W14, length spills into a second block
        clear_blk();
        for (int i = 0; i < 14; i++) blk[i] = 32'hA000_0000 + 32'(i);
        blk[14] = 32'h8000_0000;
        push_block(1'b1, 1'b0);
        clear_blk();
        blk[15] = 32'h0000_01C0;
        push_block(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) send(32'hA000_0000 + 32'(i), 3'd4, i == 13, 1'b0);
        wait_drain("drain_14");

        // 16 full words: padding entirely in a second block
        clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = 32'hB000_0000 + 32'(i);
        push_block(1'b1, 1'b0);
        clear_blk();
        blk[0]  = 32'h8000_0000;
        blk[15] = 32'h0000_0200;
        push_block(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) send(32'hB000_0000 + 32'(i), 3'd4, i == 15, 1'b0);
        wait_drain("drain_16");

        run_20(1'b0);
        run_20(1'b1);

        // Abort in the middle of EMIT
        clear_blk();
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
        push_block(1'b1, 1'b1);
        send(32'h6162_6300, 3'd3, 1'b1, 1'b0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(bus.out_valid === 1'b1 && bus.round == 6'd30) && n < 500);
        chk("reach_round30", {58'd0, bus.round}, 64'd30);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_in_ready",  {63'd0, bus.in_ready},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        repeat (3) @(negedge clk);
        chk("abort_no_output", {63'd0, bus.out_valid}, 64'd0);

        run_abc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_msg_padder
`default_nettype wire

// File: doc/msg_padder.md
MSG_PADDER -- requirements
Module: msg_padder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_data, input, 32 bits: message word, big-endian (first byte in [31:24]).
REQ-004 SHALL have port in_nbytes, input, 3 bits: valid bytes in in_data (0..4); values other than 4 are legal only with in_last; 0 only for the empty message.
REQ-005 SHALL have port in_last, input, 1 bit: the current word ends the message.
REQ-006 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): a word transfers when both are high on a clk edge.
REQ-007 SHALL have port out_word, output, 32 bits: feeds the expansion "in" port.
REQ-008 SHALL have port sel, output, 1 bit: feeds the expansion "sel" port; 0 selects out_word, 1 selects internal expansion.
REQ-009 SHALL have port out_valid, output, 1 bit: high during each of the 64 round cycles of a block.
REQ-010 SHALL have port round, output, 6 bits: round index 0..63 while out_valid is high.
REQ-011 SHALL have ports blk_first (output, 1 bit) and msg_done (output, 1 bit): one-cycle pulses, on round 0 of a message's first block and on round 63 of its final block respectively.

Function
REQ-012 SHALL run FSM states COLLECT, FILL and EMIT and hold a 16x32 block buffer, a 4-bit word index idx, a 64-bit bit-length counter and the flags marker_done and first_blk.
REQ-013 COLLECT: SHALL drive in_ready=1 and store each accepted word at buf[idx], adding 8*in_nbytes to the length counter (modulo 2^64).
REQ-014 In COLLECT, an accepted non-last word at idx=15 SHALL move the FSM to EMIT; otherwise idx SHALL increment.
REQ-015 A last word with in_nbytes<4 SHALL be stored with byte in_nbytes forced to 0x80 and all lower bytes zeroed, inputs beyond the valid bytes ignored; marker_done SHALL be set, idx SHALL increment, and the FSM SHALL move to FILL.
REQ-016 A last word with in_nbytes=4 SHALL be stored unchanged with marker_done=0; the FSM SHALL move to FILL, or to EMIT if idx was 15.
REQ-017 FILL: in_ready SHALL be 0, one word SHALL be written per cycle at idx, and idx SHALL increment.
REQ-018 In FILL, if marker_done=0 the word SHALL be 0x80000000 and marker_done SHALL be set; else at idx=14 with the marker at idx<=13 or in an earlier block, the word SHALL be length[63:32]; at idx=15 under the same condition it SHALL be length[31:0]; all other writes SHALL be 0.
REQ-019 A FILL write at idx=15 SHALL move the FSM to EMIT; the block SHALL be final only if that write is length[31:0].
REQ-020 EMIT: for 64 consecutive cycles k=0..63, SHALL drive out_valid=1 and round=k; for k<16, sel=0 and out_word=buf[k]; for k>=16, sel=1 and out_word=0.
REQ-021 EMIT SHALL never stall; in_ready SHALL be 0 throughout.
REQ-022 After EMIT, the FSM SHALL go to FILL with idx=0 if the message is pending padding, else to COLLECT with idx=0.
REQ-023 After a final block, the length counter, marker_done and first_blk SHALL be reinitialised for the next message.
REQ-024 Outside EMIT, outputs SHALL be out_valid=0, sel=0, out_word=0 and round=0.

Reset
REQ-025 With rst_n low at a clk edge, the block SHALL enter COLLECT with idx=0, length=0, marker_done=0 and first_blk=1, and SHALL drive in_ready=0, out_valid=0, sel=0, out_word=0, round=0, blk_first=0 and msg_done=0 during reset.
REQ-026 Reset asserted mid-EMIT or mid-FILL SHALL abort the message with no msg_done pulse; buffer contents need not be cleared.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, BLK_WORDS=16, ROUNDS=64 and the marker constant 0x80000000.
REQ-028 The final-word byte masking and marker insertion SHALL be one sub-module, pad_word, and the rest SHALL be inline.

Verification
REQ-029 "abc": in_data=0x61626300, in_nbytes=3, in_last -> one block: W0=0x61626380, W1..W14=0, W15=0x00000018; sel=1 exactly for rounds 16..63; msg_done at round 63.
REQ-030 Empty message: in_nbytes=0, in_last -> W0=0x80000000, all other words 0.
REQ-031 14 full words -> block 1 with W14=0x80000000 and W15=0, no msg_done; block 2 with W0..W14=0 and W15=0x000001C0, msg_done.
REQ-032 16 full words -> block 1 equal to the data; block 2 with W0=0x80000000 and W15=0x00000200.
REQ-033 Random in_valid gaps with a 20-word message -> output identical to the gap-free run; in_ready low throughout every EMIT.
REQ-034 rst_n low at round 30 -> next cycle out_valid=0 and in_ready=1 after release; a following "abc" is padded correctly.
